// File: rtl/cla_multiword_sequencer.sv
// -----------------------------------------------------------------------------
// cla_multiword_sequencer
//
// Adds or subtracts two WIDTH-bit operands by running one 4-bit carry-lookahead
// slice repeatedly, least significant nibble first. A register holds the carry
// between nibbles. There is no wide adder. Both sides use valid/ready
// handshakes.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   producer presents an operation
//   in_ready   sequencer can accept (IDLE and out of reset)
//   op_a       operand A                                  [WIDTH-1:0]
//   op_b       operand B                                  [WIDTH-1:0]
//   cin        carry-in for add (ignored when sub=1)
//   sub        1 = A-B, 0 = A+B+cin
//   out_valid  result is valid (DONE)
//   out_ready  consumer accepts the result
//   result     {carry_out, sum}                           [WIDTH:0]
//   overflow   two's-complement overflow of the WIDTH-bit sum
//   busy       high in RUN or DONE
// -----------------------------------------------------------------------------

// 4-bit carry-lookahead adder slice: every carry is computed directly from the
// generate/propagate terms, so no carry ripples inside the slice.
module carry_lookahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

module cla_multiword_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             overflow,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / 4;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   a_q,        a_d;
  logic [WIDTH-1:0]   b_q,        b_d;       // already inverted for subtract
  logic               carry_q,    carry_d;
  logic               sub_q,      sub_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   sum_q,      sum_d;
  logic [WIDTH:0]     result_q,   result_d;
  logic               overflow_q, overflow_d;

  // Slice operands: the nibble selected by the chunk counter.
  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_sum;
  logic       slice_cout;

  assign slice_a = a_q[{cnt_q, 2'b00} +: 4];
  assign slice_b = b_q[{cnt_q, 2'b00} +: 4];

  carry_lookahead_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Signed overflow, judged on the MSB nibble pass. b_q holds ~op_b for a
  // subtract, so the sign of the original B is recovered with sub_q. A subtract
  // overflows only when the original operands differ in sign. An add overflows
  // only when they share a sign. In both cases the sum's sign must also differ
  // from A's sign.
  logic a_msb;
  logic b_op_msb;
  logic sign_risk;
  logic msb_overflow;

  assign a_msb        = a_q[WIDTH-1];
  assign b_op_msb     = b_q[WIDTH-1] ^ sub_q;
  assign sign_risk    = sub_q ? (a_msb != b_op_msb) : (a_msb == b_op_msb);
  assign msb_overflow = sign_risk && (slice_sum[3] != a_msb);

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every variable gets a default before the case, so paths that do not
    // assign it hold the register value and no latch is inferred. Blocking
    // assignments are correct here because this is combinational logic.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    sub_d      = sub_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
          sub_d   = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d[{cnt_q, 2'b00} +: 4] = slice_sum;
        carry_d                    = slice_cout;
        if (cnt_q == LAST_CNT) begin
          // The visible result changes only here. During RUN the consumer
          // still sees the previous result.
          result_d   = {slice_cout, sum_d};
          overflow_d = msb_overflow;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so that all flops
    // update together from pre-edge values. Every register is reset, including
    // the datapath, so an abort leaves no stale operand or carry behind.
    if (!rstn) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      sub_q      <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      sub_q      <= sub_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  // in_ready is gated by rstn so the producer sees "not ready" during reset,
  // even though the state register already reads IDLE.
  assign in_ready  = (state_q == IDLE) && rstn;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule
